fifo_v2: RTL and testbench

FIFO_V2 -- requirements
Module: fifo_v2

---
 rtl/fifo_v2_pkg.sv | 30 +++
 rtl/fifo_v2_mem.sv | 38 +++
 rtl/fifo_v2.sv | 86 ++++++++
 tb/tb_fifo_v2.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_v2_pkg.sv
// fifo_v2 shared constants and helpers.
// Build option: FIFO_V2_ERR_FLAGS_EN adds overflow/underflow outputs.
package fifo_v2_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  function automatic op_e op_decode(
    input logic wr,
    input logic rd
  );
    op_e op;
    op = OP_IDLE;
    unique case (1'b1)
      (wr && rd):  op = OP_RW;
      (wr && !rd): op = OP_WR;
      (!wr && rd): op = OP_RD;
      default:     op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_v2_mem.sv
// fifo_v2 storage: register array, one sync write port,
// one sync read port with a resettable output register.
module fifo_v2_mem
  import fifo_v2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rd_data holds whenever no read is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_v2.sv
// fifo_v2: synchronous FIFO, pointer and flag control.
// Build option: FIFO_V2_ERR_FLAGS_EN adds overflow/underflow outputs.
module fifo_v2
  import fifo_v2_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef FIFO_V2_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;
  op_e                 op;

  // flags depend only on pointer registers
  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
    (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_acc = write_enable && !full && !rst;
  assign rd_acc = read_enable && !empty && !rst;
  assign op     = op_decode(wr_acc, rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      unique case (op)
        OP_WR: wr_ptr <= wr_ptr + PTR_ONE;
        OP_RD: rd_ptr <= rd_ptr + PTR_ONE;
        OP_RW: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_V2_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write_enable && full;
      underflow <= read_enable && empty;
    end
  end
`endif

  fifo_v2_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_v2.sv
// Directed self-checking bench for fifo_v2.
// Define FIFO_V2_ERR_FLAGS_EN to also check overflow/underflow.
module tb_fifo_v2;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef FIFO_V2_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int errors = 0;
  int checks = 0;

  fifo_v2 dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty)
`ifdef FIFO_V2_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       we,
    input logic       re,
    input logic [7:0] d
  );
    write_enable = we;
    read_enable  = re;
    data_in      = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    write_enable = 1'b1;
    read_enable = 1'b1;
    data_in = 8'h77;
    repeat (10) @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_empty got=%b exp=1", empty);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL rst_full got=%b exp=0", full);
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_dout got=%h exp=00", data_out);
    end
`ifdef FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got=%b%b exp=00",
               overflow, underflow);
    end
`endif
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_ignored_wr got=%b exp=1", empty);
    end
  endtask

  task automatic test_single;
    step(1'b1, 1'b0, 8'hA5);
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL single_notempty got=%b exp=0", empty);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_dout got=%h exp=a5", data_out);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL single_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL fill15_full got=%b exp=0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fill16_full got=%b exp=1", full);
    end
    step(1'b1, 1'b0, 8'hFF);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL drop_full got=%b exp=1", full);
    end
`ifdef FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got=%b exp=1", overflow);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse got=%b exp=0", overflow);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'(i)) begin
        errors++;
        $display("FAIL fill_rd%0d got=%h exp=%h",
                 i, data_out, 8'(i));
      end
      if (i == 0) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL unfull got=%b exp=0", full);
        end
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_underflow;
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h0F) begin
      errors++;
      $display("FAIL uf_dout got=%h exp=0f", data_out);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL uf_empty got=%b exp=1", empty);
    end
`ifdef FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow got=%b exp=1", underflow);
    end
`endif
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h3C || empty !== 1'b1) begin
      errors++;
      $display("FAIL uf_ptrs got=%h/%b exp=3c/1",
               data_out, empty);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] exp;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 30; i++) begin
        b = 8'($urandom_range(0, 255));
        q.push_back(b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b1, 8'h00);
        exp = q.pop_front();
        checks++;
        if (data_out !== exp || empty !== 1'b1) begin
          errors++;
          $display("FAIL wrap p%0d i%0d got=%h/%b exp=%h/1",
                   p, i, data_out, empty, exp);
        end
      end
    end
  endtask

  task automatic test_simul_rw;
    logic [7:0] exp_tail [5];
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h20 + 8'(i));
      checks++;
      if (data_out !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL rw5_dout%0d got=%h exp=%h",
                 i, data_out, 8'h10 + 8'(i));
      end
    end
    exp_tail = '{8'h13, 8'h14, 8'h20, 8'h21, 8'h22};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (empty !== 1'b0) begin
        errors++;
        $display("FAIL rw5_occ%0d got=%b exp=0", i, empty);
      end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== exp_tail[i]) begin
        errors++;
        $display("FAIL rw5_rd%0d got=%h exp=%h",
                 i, data_out, exp_tail[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL rw5_empty got=%b exp=1", empty);
    end
    step(1'b1, 1'b1, 8'h55);
    checks++;
    if (data_out !== 8'h22 || empty !== 1'b0) begin
      errors++;
      $display("FAIL rw_empty got=%h/%b exp=22/0",
               data_out, empty);
    end
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h55 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rw_empty_rd got=%h/%b exp=55/1",
               data_out, empty);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    checks++;
    if (data_out !== 8'h60 || full !== 1'b0) begin
      errors++;
      $display("FAIL rw_full got=%h/%b exp=60/0",
               data_out, full);
    end
`ifdef FIFO_V2_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL rw_full_ovf got=%b exp=1", overflow);
    end
`endif
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'h60 + 8'(i)) begin
        errors++;
        $display("FAIL rw_full_rd%0d got=%h exp=%h",
                 i, data_out, 8'h60 + 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL rw_full_drop got=%b exp=1", empty);
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h90 + 8'(i));
    rst = 1'b1;
    step(1'b1, 1'b1, 8'h99);
    rst = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst got=%b/%b/%h exp=1/0/00",
               empty, full, data_out);
    end
    step(1'b1, 1'b0, 8'h42);
    step(1'b0, 1'b1, 8'h00);
    checks++;
    if (data_out !== 8'h42 || empty !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rd got=%h/%b exp=42/1",
               data_out, empty);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_in = 8'h00;
    write_enable = 1'b0;
    read_enable = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_underflow();
    test_wrap();
    test_simul_rw();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
